// File: rtl/comparator_pulse_sequencer_if.sv
// Slow-control / pulser / readout bundle for the comparator pulse sequencer.
// The sequencer takes the slave view; the register file or bench drives the master view.
`timescale 1ns/1ps
interface comparator_pulse_sequencer_if #(
    parameter int NHS   = 32,
    parameter int CNT_W = 32,
    parameter int DLY_W = 4,
    parameter int PW_W  = 4,
    parameter int NP_W  = 16
);
    logic             fire_pulse;
    logic             abort;
    logic [NP_W-1:0]  num_pulses;
    logic [DLY_W-1:0] bx_delay;
    logic [PW_W-1:0]  pulse_width;
    logic             compin_inject;
    logic [NHS-1:0]   halfstrips;
    logic [NHS-1:0]   halfstrips_expect;
    logic             compout;
    logic             compout_expect;
    logic             halfstrips_errcnt_rst;
    logic             compout_errcnt_rst;

    logic             pulse_en;
    logic             compin;
    logic             pulser_ready;
    logic             done;
    logic [CNT_W-1:0] halfstrips_errcnt;
    logic [CNT_W-1:0] compout_errcnt;
    logic [NHS-1:0]   halfstrips_errmask;
    logic [CNT_W-1:0] pulse_cnt;

    modport master (
        output fire_pulse, abort, num_pulses, bx_delay, pulse_width, compin_inject,
        output halfstrips, halfstrips_expect, compout, compout_expect,
        output halfstrips_errcnt_rst, compout_errcnt_rst,
        input  pulse_en, compin, pulser_ready, done,
        input  halfstrips_errcnt, compout_errcnt, halfstrips_errmask, pulse_cnt
    );

    modport slave (
        input  fire_pulse, abort, num_pulses, bx_delay, pulse_width, compin_inject,
        input  halfstrips, halfstrips_expect, compout, compout_expect,
        input  halfstrips_errcnt_rst, compout_errcnt_rst,
        output pulse_en, compin, pulser_ready, done,
        output halfstrips_errcnt, compout_errcnt, halfstrips_errmask, pulse_cnt
    );
endinterface

// File: rtl/comparator_pulse_sequencer.sv
// Burst pulser for comparator test boards: fires N (or free-running) pulses and
// checks the half-strip / compout readout at a programmable BX after each pulse.
`timescale 1ns/1ps
module comparator_pulse_sequencer #(
    parameter int NHS   = 32,
    parameter int CNT_W = 32,
    parameter int DLY_W = 4,
    parameter int PW_W  = 4,
    parameter int NP_W  = 16
) (
    input logic                         clock40,
    input logic                         reset,
    comparator_pulse_sequencer_if.slave bus
);
    localparam int BX_W = (DLY_W > PW_W) ? DLY_W : PW_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // IDLE: ready | PULSE: pulse_en high | WAIT: pulse low, counting to D | SAMPLE: compare at bx==D
    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
        S_WAIT,
        S_SAMPLE
    } state_t;

    state_t           state_q, state_d;
    logic [BX_W-1:0]  bx_q, bx_d;
    logic [BX_W-1:0]  pw_q, pw_d;
    logic [BX_W-1:0]  dly_q, dly_d;
    logic [NP_W-1:0]  np_q, np_d;
    logic [NP_W-1:0]  idx_q, idx_d;
    logic             inj_q, inj_d;
    logic             abort_seen_q, abort_seen_d;
    logic             done_d;
    logic             start;
    logic             sample;

    logic             pulse_en_q;
    logic             compin_q;
    logic             ready_q;
    logic             done_q;

    logic [CNT_W-1:0] hs_cnt_q, hs_cnt_d;
    logic [CNT_W-1:0] co_cnt_q, co_cnt_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [NHS-1:0]   mask_q, mask_d;
    logic [NHS-1:0]   hs_diff;

    logic [BX_W-1:0]  pw_eff;
    logic [BX_W-1:0]  dly_eff;

    // Sampling never lands inside the pulse: D is pulled up to at least PW.
    always_comb begin
        pw_eff  = (bus.pulse_width == '0) ? BX_W'(1) : BX_W'(bus.pulse_width);
        dly_eff = (BX_W'(bus.bx_delay) > pw_eff) ? BX_W'(bus.bx_delay) : pw_eff;
    end

    always_comb begin
        state_d      = state_q;
        bx_d         = bx_q;
        pw_d         = pw_q;
        dly_d        = dly_q;
        np_d         = np_q;
        inj_d        = inj_q;
        idx_d        = idx_q;
        abort_seen_d = abort_seen_q;
        done_d       = 1'b0;
        start        = 1'b0;
        sample       = 1'b0;

        if (state_q != S_IDLE && bus.abort) begin
            abort_seen_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.fire_pulse) begin
                    start        = 1'b1;
                    pw_d         = pw_eff;
                    dly_d        = dly_eff;
                    np_d         = bus.num_pulses;
                    inj_d        = bus.compin_inject;
                    idx_d        = '0;
                    abort_seen_d = 1'b0;
                    bx_d         = '0;
                    state_d      = S_PULSE;
                end
            end
            S_PULSE: begin
                bx_d = bx_q + BX_W'(1);
                if (bx_q == pw_q - BX_W'(1)) begin
                    state_d = (dly_q == pw_q) ? S_SAMPLE : S_WAIT;
                end
            end
            S_WAIT: begin
                bx_d = bx_q + BX_W'(1);
                if (bx_q == dly_q - BX_W'(1)) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                sample = 1'b1;
                idx_d  = idx_q + NP_W'(1);
                bx_d   = '0;
                if ((np_q != '0 && idx_q + NP_W'(1) == np_q) || abort_seen_q || bus.abort) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_PULSE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A clear in the same cycle as a sample wins; that sample's increment is dropped.
    always_comb begin
        hs_diff  = bus.halfstrips ^ bus.halfstrips_expect;
        hs_cnt_d = hs_cnt_q;
        co_cnt_d = co_cnt_q;
        mask_d   = mask_q;
        pcnt_d   = pcnt_q;

        if (bus.halfstrips_errcnt_rst) begin
            hs_cnt_d = '0;
            mask_d   = '0;
        end else if (sample) begin
            mask_d = mask_q | hs_diff;
            if ((|hs_diff) && hs_cnt_q != CNT_MAX) begin
                hs_cnt_d = hs_cnt_q + CNT_W'(1);
            end
        end

        if (bus.compout_errcnt_rst) begin
            co_cnt_d = '0;
        end else if (sample && (bus.compout != bus.compout_expect) && co_cnt_q != CNT_MAX) begin
            co_cnt_d = co_cnt_q + CNT_W'(1);
        end

        if (start) begin
            pcnt_d = '0;
        end else if (sample && pcnt_q != CNT_MAX) begin
            pcnt_d = pcnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock40) begin
        if (reset) begin
            state_q      <= S_IDLE;
            bx_q         <= '0;
            pw_q         <= BX_W'(1);
            dly_q        <= BX_W'(1);
            np_q         <= '0;
            idx_q        <= '0;
            inj_q        <= 1'b0;
            abort_seen_q <= 1'b0;
            pulse_en_q   <= 1'b0;
            compin_q     <= 1'b0;
            ready_q      <= 1'b1;
            done_q       <= 1'b0;
            hs_cnt_q     <= '0;
            co_cnt_q     <= '0;
            mask_q       <= '0;
            pcnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            bx_q         <= bx_d;
            pw_q         <= pw_d;
            dly_q        <= dly_d;
            np_q         <= np_d;
            idx_q        <= idx_d;
            inj_q        <= inj_d;
            abort_seen_q <= abort_seen_d;
            pulse_en_q   <= (state_d == S_PULSE);
            compin_q     <= (state_d == S_PULSE) && inj_d;
            ready_q      <= (state_d == S_IDLE);
            done_q       <= done_d;
            hs_cnt_q     <= hs_cnt_d;
            co_cnt_q     <= co_cnt_d;
            mask_q       <= mask_d;
            pcnt_q       <= pcnt_d;
        end
    end

    assign bus.pulse_en           = pulse_en_q;
    assign bus.compin             = compin_q;
    assign bus.pulser_ready       = ready_q;
    assign bus.done               = done_q;
    assign bus.halfstrips_errcnt  = hs_cnt_q;
    assign bus.compout_errcnt     = co_cnt_q;
    assign bus.halfstrips_errmask = mask_q;
    assign bus.pulse_cnt          = pcnt_q;
endmodule

// File: tb/tb_comparator_pulse_sequencer.sv
// Bench for comparator_pulse_sequencer: directed bursts plus random bursts, checked each
// cycle against a timeline model; a second instance with 4-bit counters exercises saturation.
`timescale 1ns/1ps
module tb_comparator_pulse_sequencer;
    localparam int NHS   = 32;
    localparam int DLY_W = 4;
    localparam int PW_W  = 4;
    localparam int NP_W  = 16;

    logic clock40;
    logic reset;

    comparator_pulse_sequencer_if #(.NHS(NHS), .CNT_W(32), .DLY_W(DLY_W), .PW_W(PW_W), .NP_W(NP_W)) sif ();
    comparator_pulse_sequencer_if #(.NHS(NHS), .CNT_W(4),  .DLY_W(DLY_W), .PW_W(PW_W), .NP_W(NP_W)) sif4 ();

    comparator_pulse_sequencer #(.NHS(NHS), .CNT_W(32), .DLY_W(DLY_W), .PW_W(PW_W), .NP_W(NP_W)) dut (
        .clock40 (clock40),
        .reset   (reset),
        .bus     (sif.slave)
    );

    comparator_pulse_sequencer #(.NHS(NHS), .CNT_W(4), .DLY_W(DLY_W), .PW_W(PW_W), .NP_W(NP_W)) dut4 (
        .clock40 (clock40),
        .reset   (reset),
        .bus     (sif4.slave)
    );

    assign sif4.fire_pulse            = sif.fire_pulse;
    assign sif4.abort                 = sif.abort;
    assign sif4.num_pulses            = sif.num_pulses;
    assign sif4.bx_delay              = sif.bx_delay;
    assign sif4.pulse_width           = sif.pulse_width;
    assign sif4.compin_inject         = sif.compin_inject;
    assign sif4.halfstrips            = sif.halfstrips;
    assign sif4.halfstrips_expect     = sif.halfstrips_expect;
    assign sif4.compout               = sif.compout;
    assign sif4.compout_expect        = sif.compout_expect;
    assign sif4.halfstrips_errcnt_rst = sif.halfstrips_errcnt_rst;
    assign sif4.compout_errcnt_rst    = sif.compout_errcnt_rst;

    initial clock40 = 1'b0;
    always #12.5 clock40 = ~clock40;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic longint sat(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    // Timeline model: a burst is a start time plus latched PW/D; everything else is
    // derived from the cycle offset since the burst started.
    bit     m_valid = 0;
    bit     m_busy  = 0;
    bit     m_ab    = 0;
    bit     m_inj   = 0;
    int     m_pw    = 1;
    int     m_d     = 1;
    int     m_np    = 0;
    int     m_rel   = 0;
    longint m_pc    = 0;
    longint m_hs    = 0;
    longint m_co    = 0;
    logic [NHS-1:0] m_mask = '0;
    bit     m_pen   = 0;
    bit     m_cin   = 0;
    bit     m_done  = 0;
    bit     m_ready = 1;

    always @(posedge clock40) begin : model
        bit smp;
        bit hs_m;
        bit co_m;
        logic [NHS-1:0] x;
        smp    = 0;
        hs_m   = 0;
        co_m   = 0;
        x      = '0;
        m_done = 0;
        if (reset) begin
            m_busy = 0;
            m_hs   = 0;
            m_co   = 0;
            m_mask = '0;
            m_pc   = 0;
            m_rel  = 0;
        end else begin
            if (!m_busy) begin
                if (sif.fire_pulse) begin
                    m_pw   = (sif.pulse_width == 0) ? 1 : int'(sif.pulse_width);
                    m_d    = (int'(sif.bx_delay) > m_pw) ? int'(sif.bx_delay) : m_pw;
                    m_np   = int'(sif.num_pulses);
                    m_inj  = sif.compin_inject;
                    m_busy = 1;
                    m_rel  = 0;
                    m_pc   = 0;
                    m_ab   = 0;
                end
            end else begin
                if (sif.abort) m_ab = 1;
                smp = (m_rel % (m_d + 1)) == m_d;
                if (smp) begin
                    x    = sif.halfstrips ^ sif.halfstrips_expect;
                    hs_m = (x != '0);
                    co_m = (sif.compout != sif.compout_expect);
                    m_pc++;
                    if (m_ab || (m_np != 0 && m_pc == longint'(m_np))) begin
                        m_busy = 0;
                        m_done = 1;
                    end
                end
                m_rel++;
            end
            if (sif.halfstrips_errcnt_rst) begin
                m_hs   = 0;
                m_mask = '0;
            end else if (smp) begin
                m_hs   = m_hs + longint'(hs_m);
                m_mask = m_mask | x;
            end
            if (sif.compout_errcnt_rst) m_co = 0;
            else if (smp)               m_co = m_co + longint'(co_m);
        end
        m_ready = !m_busy;
        m_pen   = m_busy && ((m_rel % (m_d + 1)) < m_pw);
        m_cin   = m_pen && m_inj;
        m_valid = 1;
    end

    always @(negedge clock40) begin
        if (m_valid) begin
            chk("pulse_en",           sif.pulse_en,           m_pen);
            chk("compin",             sif.compin,             m_cin);
            chk("done",               sif.done,               m_done);
            chk("pulser_ready",       sif.pulser_ready,       m_ready);
            chk("halfstrips_errcnt",  sif.halfstrips_errcnt,  sat(m_hs, 64'd4294967295));
            chk("compout_errcnt",     sif.compout_errcnt,     sat(m_co, 64'd4294967295));
            chk("halfstrips_errmask", sif.halfstrips_errmask, m_mask);
            chk("pulse_cnt",          sif.pulse_cnt,          sat(m_pc, 64'd4294967295));
            chk("w4_done",            sif4.done,              m_done);
            chk("w4_halfstrips_errcnt", sif4.halfstrips_errcnt, sat(m_hs, 15));
            chk("w4_compout_errcnt",  sif4.compout_errcnt,    sat(m_co, 15));
            chk("w4_pulse_cnt",       sif4.pulse_cnt,         sat(m_pc, 15));
        end
    end

    task automatic step();
        @(posedge clock40);
        #1;
    endtask

    task automatic set_random_obs();
        sif.halfstrips_expect = $urandom;
        sif.halfstrips        = $urandom;
        sif.compout_expect    = 1'($urandom);
        sif.compout           = 1'($urandom);
    endtask

    task automatic clear_ctrl();
        sif.fire_pulse            = 1'b0;
        sif.abort                 = 1'b0;
        sif.halfstrips_errcnt_rst = 1'b0;
        sif.compout_errcnt_rst    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            clear_ctrl();
            sif.abort = ($urandom_range(0, 3) == 0);
            set_random_obs();
        end
    endtask

    task automatic clear_counters();
        step();
        clear_ctrl();
        sif.halfstrips_errcnt_rst = 1'b1;
        sif.compout_errcnt_rst    = 1'b1;
        step();
        clear_ctrl();
    endtask

    // Fires in the current cycle; returns the cycle offset (from fire) at which done was seen.
    // mode 0: readout matches, 1: half-strip bit 5 wrong on pulses 2 and 7,
    // 2: compout always wrong, 3: random mismatches, stray fire/abort/clears.
    task automatic run_burst(input int np, input int dly, input int pw, input bit inj,
                             input int mode, input int abort_k, input int clr_k,
                             output int c_done);
        int pw_e;
        int d_e;
        int rel;
        int k;
        bit smp;
        pw_e = (pw == 0) ? 1 : pw;
        d_e  = (dly > pw_e) ? dly : pw_e;
        clear_ctrl();
        sif.num_pulses    = NP_W'(np);
        sif.bx_delay      = DLY_W'(dly);
        sif.pulse_width   = PW_W'(pw);
        sif.compin_inject = inj;
        sif.fire_pulse    = 1'b1;
        set_random_obs();
        c_done = -1;
        for (int c = 1; c <= 4000; c++) begin
            step();
            clear_ctrl();
            if (sif.done) begin
                c_done = c;
                break;
            end
            sif.num_pulses    = NP_W'($urandom);
            sif.bx_delay      = DLY_W'($urandom);
            sif.pulse_width   = PW_W'($urandom);
            sif.compin_inject = 1'($urandom);
            set_random_obs();
            rel = c - 1;
            k   = rel / (d_e + 1);
            smp = (rel % (d_e + 1)) == d_e;
            if (smp) begin
                sif.halfstrips = sif.halfstrips_expect;
                sif.compout    = sif.compout_expect;
                case (mode)
                    1: if (k == 2 || k == 7) sif.halfstrips[5] = ~sif.halfstrips[5];
                    2: sif.compout = ~sif.compout_expect;
                    3: begin
                        if ($urandom_range(0, 2) == 0) sif.halfstrips = sif.halfstrips ^ $urandom;
                        if ($urandom_range(0, 2) == 0) sif.compout = ~sif.compout_expect;
                    end
                    default: ;
                endcase
                if (k == clr_k) sif.compout_errcnt_rst = 1'b1;
            end
            if (k == abort_k && (rel % (d_e + 1)) == 0) sif.abort = 1'b1;
            if (mode == 3) begin
                sif.fire_pulse = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 39) == 0) sif.abort = 1'b1;
                if ($urandom_range(0, 29) == 0) sif.halfstrips_errcnt_rst = 1'b1;
                if ($urandom_range(0, 29) == 0) sif.compout_errcnt_rst = 1'b1;
            end
        end
        chk("burst_end_seen", (c_done != -1), 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int c;
        int np;
        int ak;
        reset = 1'b1;
        clear_ctrl();
        sif.num_pulses    = 16'd1;
        sif.bx_delay      = 4'd4;
        sif.pulse_width   = 4'd2;
        sif.compin_inject = 1'b0;
        set_random_obs();
        repeat (3) step();
        chk("rst_pulse_en", sif.pulse_en, 0);
        chk("rst_compin", sif.compin, 0);
        chk("rst_done", sif.done, 0);
        chk("rst_ready", sif.pulser_ready, 1);
        chk("rst_hs_cnt", sif.halfstrips_errcnt, 0);
        chk("rst_co_cnt", sif.compout_errcnt, 0);
        chk("rst_mask", sif.halfstrips_errmask, 0);
        chk("rst_pulse_cnt", sif.pulse_cnt, 0);
        reset = 1'b0;
        idle(3);

        run_burst(1, 4, 2, 1'b1, 0, -1, -1, c);
        chk("t1_done_latency", c, 6);
        chk("t1_pulse_cnt", sif.pulse_cnt, 1);
        chk("t1_hs_cnt", sif.halfstrips_errcnt, 0);
        chk("t1_co_cnt", sif.compout_errcnt, 0);

        clear_counters();
        run_burst(10, 3, 1, 1'b0, 1, -1, -1, c);
        chk("t2_done_latency", c, 41);
        chk("t2_hs_cnt", sif.halfstrips_errcnt, 2);
        chk("t2_mask", sif.halfstrips_errmask, 32'h20);
        chk("t2_pulse_cnt", sif.pulse_cnt, 10);
        chk("t2_co_cnt", sif.compout_errcnt, 0);

        run_burst(3, 0, 0, 1'b1, 0, -1, -1, c);
        chk("t3_min_cfg_latency", c, 7);
        run_burst(2, 2, 6, 1'b0, 0, -1, -1, c);
        chk("t3_wide_pulse_latency", c, 15);

        clear_counters();
        run_burst(0, 1, 1, 1'b0, 2, 50, -1, c);
        chk("t4_done_latency", c, 103);
        chk("t4_pulse_cnt", sif.pulse_cnt, 51);
        chk("t4_co_cnt", sif.compout_errcnt, 51);
        chk("t4_w4_co_sat", sif4.compout_errcnt, 15);
        chk("t4_w4_pcnt_sat", sif4.pulse_cnt, 15);

        clear_counters();
        run_burst(3, 2, 1, 1'b0, 2, -1, 2, c);
        chk("t5_clear_beats_inc", sif.compout_errcnt, 0);
        run_burst(3, 1, 1, 1'b0, 1, -1, -1, c);
        chk("t5_mask_set", sif.halfstrips_errmask, 32'h20);
        sif.halfstrips_errcnt_rst = 1'b1;
        step();
        clear_ctrl();
        chk("t5_mask_cleared", sif.halfstrips_errmask, 0);
        chk("t5_hs_cleared", sif.halfstrips_errcnt, 0);

        clear_counters();
        sif.num_pulses        = 16'd5;
        sif.bx_delay          = 4'd3;
        sif.pulse_width       = 4'd1;
        sif.compin_inject     = 1'b1;
        sif.halfstrips_expect = 32'h1234_5678;
        sif.halfstrips        = 32'h1234_5678;
        sif.compout_expect    = 1'b0;
        sif.compout           = 1'b1;
        sif.fire_pulse        = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            sif.fire_pulse = 1'b0;
        end
        chk("t6_co_before_reset", sif.compout_errcnt, 2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_pulse_en", sif.pulse_en, 0);
        chk("t6_ready", sif.pulser_ready, 1);
        chk("t6_no_done", sif.done, 0);
        chk("t6_co_cnt", sif.compout_errcnt, 0);
        chk("t6_pulse_cnt", sif.pulse_cnt, 0);
        run_burst(2, 2, 1, 1'b1, 0, -1, -1, c);
        chk("t6_restart_latency", c, 7);
        chk("t6_restart_pulse_cnt", sif.pulse_cnt, 2);

        for (int i = 0; i < 16; i++) begin
            np = $urandom_range(0, 6);
            ak = (np == 0 || $urandom_range(0, 2) == 0) ? $urandom_range(0, 5) : -1;
            run_burst(np, $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom),
                      3, ak, $urandom_range(0, 6), c);
            idle($urandom_range(0, 3));
        end

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
